// File: rtl/data_mem_responder.sv
// data_mem_responder: memory-side responder for the processor load/store port.
// Accepts one word request per transaction through a valid/ready handshake,
// holds it for WAIT_STATES cycles, then commits writes to a word-addressed
// array and returns a one-cycle registered response.
//
// Optional feature macro: DMEM_ALIGN_CHECK_EN
//   defined   -> addr[1:0] != 0 raises resp_err, returns zero data and
//                suppresses the store.
//   undefined -> resp_err is tied low and addr[1:0] is ignored.
//
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready were both 1 in the preceding cycle. req_ready depends on the FSM
// state only. resp_valid is a one-cycle pulse with no back-pressure.
module data_mem_responder #(
  parameter int DEPTH_WORDS = 64,
  parameter int WAIT_STATES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [1:0]  dbg_state
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [3:0]      wait_cnt_q, wait_cnt_d;
  logic [AW+1:0]   addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic            write_q, write_d;

  logic            resp_valid_q;
  logic [31:0]     resp_rdata_q;
  logic            resp_err_q;

  logic [31:0]     mem_q [DEPTH_WORDS];

  // Request seen by the commit/response logic: live inputs when the response
  // follows acceptance directly, otherwise the holding registers.
  logic            go_resp;
  logic [AW+1:0]   cur_addr;
  logic [31:0]     cur_wdata;
  logic            cur_write;
  logic [AW-1:0]   cur_idx;
  logic            misaligned;

  // Upper address bits are deliberately dropped so addresses wrap.
  logic            unused_addr_bits;
  assign unused_addr_bits = ^req_addr[31:AW+2];

  // State register plus holding registers and wait counter.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      wait_cnt_q <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      write_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      write_q    <= write_d;
    end
  end

  // Next-state logic; holding registers load only on acceptance.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    write_d    = write_q;
    go_resp    = 1'b0;
    cur_addr   = addr_q;
    cur_wdata  = wdata_q;
    cur_write  = write_q;
    case (state_q)
      ST_IDLE: begin
        cur_addr  = req_addr[AW+1:0];
        cur_wdata = req_wdata;
        cur_write = req_write;
        if (req_valid) begin
          addr_d     = req_addr[AW+1:0];
          wdata_d    = req_wdata;
          write_d    = req_write;
          wait_cnt_d = WAIT_INIT;
          if (WAIT_STATES == 0) begin
            state_d = ST_RESP;
            go_resp = 1'b1;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        wait_cnt_d = wait_cnt_q - 4'd1;
        if (wait_cnt_q == 4'd1) begin
          state_d = ST_RESP;
          go_resp = 1'b1;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign cur_idx = cur_addr[AW+1:2];

`ifdef DMEM_ALIGN_CHECK_EN
  assign misaligned = (cur_addr[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  // Storage array: not reset; a store commits on the edge entering RESP.
  always_ff @(posedge clock) begin
    if (go_resp && cur_write && !misaligned && !reset) begin
      mem_q[cur_idx] <= cur_wdata;
    end
  end

  // Registered response; rdata and err hold between responses.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      resp_valid_q <= go_resp;
      if (go_resp) begin
        if (misaligned) begin
          resp_rdata_q <= '0;
          resp_err_q   <= 1'b1;
        end else begin
          resp_rdata_q <= cur_write ? cur_wdata : mem_q[cur_idx];
          resp_err_q   <= 1'b0;
        end
      end
    end
  end

  assign req_ready  = (state_q == ST_IDLE);
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Testbench for data_mem_responder (DEPTH_WORDS=64, WAIT_STATES=2).
module tb_data_mem_responder;

  localparam int WS = 2;
  localparam int DW = 64;
  localparam int PERIOD = 10;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        req_ready;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [1:0]  dbg_state;

  int tests_run = 0;
  int tests_failed = 0;

  logic [31:0] exp_q[$];
  logic        exp_err_q[$];
  time         acc_q[$];
  logic [31:0] model_mem [DW];
  logic        prev_valid = 1'b0;

  data_mem_responder #(.DEPTH_WORDS(DW), .WAIT_STATES(WS)) dut (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .dbg_state  (dbg_state)
  );

  // Clock: posedges at 5, 15, ...; outputs sampled on negedges.
  always #(PERIOD/2) clock = ~clock;

  // Scoreboard monitor: checks busy-ready, pulse width, data, err, latency.
  always @(negedge clock) begin
    logic [31:0] e;
    logic        ee;
    time         a;
    if (acc_q.size() > 0) begin
      tests_run++;
      if (req_ready !== 1'b0) begin
        tests_failed++;
        $display("FAIL ready_busy: req_ready=%b required 0 at %0t", req_ready, $time);
      end
    end
    if (resp_valid === 1'b1) begin
      tests_run++;
      if (prev_valid !== 1'b0) begin
        tests_failed++;
        $display("FAIL resp_width: resp_valid high two cycles in a row at %0t", $time);
      end
      if (exp_q.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("FAIL unexpected_resp: rdata=%h with no pending request at %0t", resp_rdata, $time);
      end else begin
        e  = exp_q.pop_front();
        ee = exp_err_q.pop_front();
        a  = acc_q.pop_front();
        tests_run++;
        if (resp_rdata !== e) begin
          tests_failed++;
          $display("FAIL resp_rdata: got %h required %h at %0t", resp_rdata, e, $time);
        end
        tests_run++;
        if (resp_err !== ee) begin
          tests_failed++;
          $display("FAIL resp_err: got %b required %b at %0t", resp_err, ee, $time);
        end
        tests_run++;
        if (($time - a) != time'(WS*PERIOD + PERIOD/2)) begin
          tests_failed++;
          $display("FAIL latency: got %0t required %0d", $time - a, WS*PERIOD + PERIOD/2);
        end
      end
    end
    prev_valid = resp_valid;
  end

  function automatic int word_idx(input logic [31:0] a);
    return int'((a >> 2) & 32'(DW - 1));
  endfunction

  // Build the expected response for a request and update the model.
  task automatic predict(input logic w, input logic [31:0] a, input logic [31:0] d,
                         output logic [31:0] e, output logic ee);
    logic mis;
`ifdef DMEM_ALIGN_CHECK_EN
    mis = (a[1:0] != 2'b00);
`else
    mis = 1'b0;
`endif
    if (mis) begin
      e = '0; ee = 1'b1;
    end else if (w) begin
      e = d; ee = 1'b0;
      model_mem[word_idx(a)] = d;
    end else begin
      e = model_mem[word_idx(a)]; ee = 1'b0;
    end
  endtask

  // Issue one request from a negedge; returns at the negedge after acceptance.
  task automatic do_req(input logic w, input logic [31:0] a, input logic [31:0] d);
    logic [31:0] e;
    logic        ee;
    int          n;
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
    n = 0;
    while (req_ready !== 1'b1 && n < 40) begin
      @(negedge clock);
      n++;
    end
    if (n >= 40) begin
      tests_run++;
      tests_failed++;
      $display("FAIL accept_timeout: req_ready=%b required 1", req_ready);
      req_valid = 1'b0;
      return;
    end
    @(posedge clock);
    predict(w, a, d, e, ee);
    exp_q.push_back(e);
    exp_err_q.push_back(ee);
    acc_q.push_back($time);
    @(negedge clock);
    req_valid = 1'b0;
  endtask

  // Wait until every expected response has been seen, with a cycle budget.
  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 60) begin
      @(negedge clock);
      n++;
    end
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL drain_timeout: pending=%0d required 0", exp_q.size());
      exp_q.delete(); exp_err_q.delete(); acc_q.delete();
    end
    @(negedge clock);
  endtask

  task automatic test_reset();
    #2 reset = 1'b1;
    #1;
    tests_run++;
    if (req_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_ready: got %b required 1", req_ready); end
    tests_run++;
    if (resp_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %b required 0", resp_valid); end
    tests_run++;
    if (resp_rdata !== 32'h0) begin tests_failed++; $display("FAIL reset_rdata: got %h required 0", resp_rdata); end
    tests_run++;
    if (resp_err !== 1'b0) begin tests_failed++; $display("FAIL reset_err: got %b required 0", resp_err); end
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_write_read();
    do_req(1'b1, 32'h10, 32'hDEADBEEF);
    drain();
    do_req(1'b0, 32'h10, 32'h0);
    drain();
  endtask

  task automatic test_back_to_back();
    time prev_acc;
    logic [31:0] e;
    logic ee;
    int n;
    for (int i = 0; i < 4; i++) begin
      do_req(1'b1, 32'h40 + 32'(4*i), $urandom);
      drain();
    end
    prev_acc = 0;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h40; req_wdata = '0;
    for (int i = 0; i < 4; i++) begin
      n = 0;
      while (req_ready !== 1'b1 && n < 40) begin
        @(negedge clock);
        n++;
      end
      @(posedge clock);
      predict(1'b0, req_addr, 32'h0, e, ee);
      exp_q.push_back(e);
      exp_err_q.push_back(ee);
      acc_q.push_back($time);
      if (i > 0) begin
        tests_run++;
        if (($time - prev_acc) != time'((WS + 2) * PERIOD)) begin
          tests_failed++;
          $display("FAIL b2b_spacing: got %0t required %0d", $time - prev_acc, (WS + 2) * PERIOD);
        end
      end
      prev_acc = $time;
      @(negedge clock);
      req_addr = 32'h40 + 32'(4*(i+1));
    end
    req_valid = 1'b0;
    drain();
  endtask

  task automatic test_wrap();
    do_req(1'b1, 32'h100, 32'h12345678);
    drain();
    do_req(1'b0, 32'h000, 32'h0);
    drain();
  endtask

  task automatic test_reset_mid();
    int seen;
    int n;
    do_req(1'b1, 32'h20, 32'h11111111);
    drain();
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h20; req_wdata = 32'hAAAA5555;
    n = 0;
    while (req_ready !== 1'b1 && n < 40) begin
      @(negedge clock);
      n++;
    end
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    tests_run++;
    if (req_ready !== 1'b1) begin tests_failed++; $display("FAIL midreset_ready: got %b required 1", req_ready); end
    @(negedge clock);
    reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      if (resp_valid === 1'b1) seen++;
    end
    tests_run++;
    if (seen != 0) begin tests_failed++; $display("FAIL midreset_resp: got %0d pulses required 0", seen); end
    do_req(1'b0, 32'h20, 32'h0);
    drain();
  endtask

  task automatic test_align();
    do_req(1'b1, 32'h22, 32'hFFFFFFFF);
    drain();
    do_req(1'b0, 32'h20, 32'h0);
    drain();
  endtask

  task automatic test_random();
    logic [31:0] a;
    for (int i = 16; i < 24; i++) begin
      a = ($urandom & 32'hFFFF_FF00) | 32'(i << 2);
      do_req(1'b1, a, $urandom);
      drain();
    end
    for (int i = 0; i < 8; i++) begin
      a = ($urandom & 32'hFFFF_FF00) | 32'($urandom_range(16, 23) << 2);
      do_req(1'b0, a, 32'h0);
      drain();
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_back_to_back();
    test_wrap();
    test_reset_mid();
    test_align();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
